serial_logic_unit: RTL

Parametrised, multi-cycle successor to the 16-bit bitwise gate family. It accepts two WIDTH-bit operands and a 3-bit op code over a valid/ready handshake. It evaluates the op SLICE bits per cycle, LSB slice first, and presents a held result with Hack-style zr/ng flags under an output handshake. It sits between operand registers and the ALU/writeback path, where area matters more than single-cycle latency.

---
 rtl/serial_logic_unit_pkg.sv | 35 +++
 rtl/serial_logic_unit_slice.sv | 44 ++++
 rtl/serial_logic_unit.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/serial_logic_unit_pkg.sv
// Shared op codes, FSM state encodings and elaboration helpers for serial_logic_unit.
// The optional popcount output is enabled by defining LOGIC_POPCNT_EN.
package serial_logic_unit_pkg;

    typedef enum logic [2:0] {
        LOGIC_AND  = 3'd0,
        LOGIC_OR   = 3'd1,
        LOGIC_XOR  = 3'd2,
        LOGIC_NAND = 3'd3,
        LOGIC_NOR  = 3'd4,
        LOGIC_XNOR = 3'd5,
        LOGIC_NOT  = 3'd6,
        LOGIC_PASS = 3'd7
    } logic_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Ceiling log2, used for counter and index widths at elaboration.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/serial_logic_unit_slice.sv
// Combinational evaluation of one SLICE-bit chunk of a bitwise op.
// With LOGIC_POPCNT_EN defined it also reports the popcount of the chunk.
module serial_logic_unit_slice
    import serial_logic_unit_pkg::*;
#(
    parameter int SLICE = 4
)
(
    input  logic_op_e        op_i,
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    output logic [SLICE-1:0] r_o
`ifdef LOGIC_POPCNT_EN
   ,output logic [clog2(SLICE+1)-1:0] pop_o
`endif
);

    always_comb begin
        r_o = '0;
        case (op_i)
            LOGIC_AND:  r_o = a_i & b_i;
            LOGIC_OR:   r_o = a_i | b_i;
            LOGIC_XOR:  r_o = a_i ^ b_i;
            LOGIC_NAND: r_o = ~(a_i & b_i);
            LOGIC_NOR:  r_o = ~(a_i | b_i);
            LOGIC_XNOR: r_o = ~(a_i ^ b_i);
            LOGIC_NOT:  r_o = ~a_i;
            LOGIC_PASS: r_o = a_i;
            default:    r_o = a_i;
        endcase
    end

`ifdef LOGIC_POPCNT_EN
    localparam int POP_W = clog2(SLICE + 1);

    always_comb begin
        pop_o = '0;
        for (int i = 0; i < SLICE; i++) begin
            pop_o = pop_o + POP_W'(r_o[i]);
        end
    end
`endif

endmodule

// File: rtl/serial_logic_unit.sv
// Multi-cycle bitwise logic unit: evaluates SLICE bits per cycle, LSB first, with zr/ng flags.
// Defining LOGIC_POPCNT_EN adds the cnt_o popcount port and its accumulator.
module serial_logic_unit
    import serial_logic_unit_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       op_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_o,
    output logic             zr_o,
    output logic             ng_o
`ifdef LOGIC_POPCNT_EN
   ,output logic [clog2(WIDTH+1)-1:0] cnt_o
`endif
);

    localparam int N     = WIDTH / SLICE;
    localparam int IDX_W = (N > 1) ? clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    generate
        if ((SLICE < 1) || ((WIDTH % SLICE) != 0)) begin : g_bad_slice
            $error("serial_logic_unit: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    state_e           state_q,    state_d;
    logic [IDX_W-1:0] sliceIdx_q, sliceIdx_d;
    logic [WIDTH-1:0] opA_q,      opA_d;
    logic [WIDTH-1:0] opB_q,      opB_d;
    logic_op_e        op_q,       op_d;
    logic [WIDTH-1:0] result_q,   result_d;
    logic             zr_q,       zr_d;
    logic             ng_q,       ng_d;

    logic [SLICE-1:0] sliceA;
    logic [SLICE-1:0] sliceB;
    logic [SLICE-1:0] sliceR;
    logic [WIDTH-1:0] resultMerged;

    assign sliceA = opA_q[int'(sliceIdx_q) * SLICE +: SLICE];
    assign sliceB = opB_q[int'(sliceIdx_q) * SLICE +: SLICE];

`ifdef LOGIC_POPCNT_EN
    localparam int CNT_W = clog2(WIDTH + 1);
    localparam int POP_W = clog2(SLICE + 1);

    logic [POP_W-1:0] slicePop;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    serial_logic_unit_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .op_i  (op_q),
        .a_i   (sliceA),
        .b_i   (sliceB),
        .r_o   (sliceR)
`ifdef LOGIC_POPCNT_EN
       ,.pop_o (slicePop)
`endif
    );

    // The flags must see the slice being written this edge, so they come from the merged word.
    always_comb begin
        state_d    = state_q;
        sliceIdx_d = sliceIdx_q;
        opA_d      = opA_q;
        opB_d      = opB_q;
        op_d       = op_q;
        result_d   = result_q;
        zr_d       = zr_q;
        ng_d       = ng_q;

        resultMerged = result_q;
        resultMerged[int'(sliceIdx_q) * SLICE +: SLICE] = sliceR;

        case (state_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    opA_d      = a_i;
                    opB_d      = b_i;
                    op_d       = logic_op_e'(op_i);
                    result_d   = '0;
                    zr_d       = 1'b0;
                    ng_d       = 1'b0;
                    sliceIdx_d = '0;
                    state_d    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                result_d   = resultMerged;
                sliceIdx_d = sliceIdx_q + 1'b1;
                if (sliceIdx_q == LAST_IDX) begin
                    zr_d       = (resultMerged == '0);
                    ng_d       = resultMerged[WIDTH-1];
                    sliceIdx_d = '0;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sliceIdx_q <= '0;
            opA_q      <= '0;
            opB_q      <= '0;
            op_q       <= LOGIC_AND;
            result_q   <= '0;
            zr_q       <= 1'b0;
            ng_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            sliceIdx_q <= sliceIdx_d;
            opA_q      <= opA_d;
            opB_q      <= opB_d;
            op_q       <= op_d;
            result_q   <= result_d;
            zr_q       <= zr_d;
            ng_q       <= ng_d;
        end
    end

`ifdef LOGIC_POPCNT_EN
    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == ST_IDLE) && in_valid_i) begin
            cnt_d = '0;
        end else if (state_q == ST_BUSY) begin
            cnt_d = cnt_q + CNT_W'(slicePop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
`endif

    assign in_ready_o  = (state_q == ST_IDLE);
    assign out_valid_o = (state_q == ST_DONE);
    assign out_o       = result_q;
    assign zr_o        = zr_q;
    assign ng_o        = ng_q;

endmodule
